// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner and fetch controller that launches, steps, redirects and halts programs
module fetch_sequencer #(
  parameter int AW = 11,
  parameter logic [AW-1:0] PROG0_BASE = AW'(0),
  parameter logic [AW-1:0] PROG1_BASE = AW'(256),
  parameter logic [AW-1:0] PROG2_BASE = AW'(512),
  parameter int CW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [1:0]    ProgSel,
  input  logic          Stall,
  input  logic          HaltReq,
  input  logic          BranchEn,
  input  logic          BranchAbs,
  input  logic [AW-1:0] Target,
  output logic [AW-1:0] InstAddress,
  output logic          InstValid,
  output logic          Busy,
  output logic          Done,
  output logic          Fault,
  output logic [CW-1:0] RetireCount
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [AW-1:0] pc_n, base;
  logic [CW-1:0] count_n;
  logic fault_n, done_n, retire;
  assign base = ProgSel == 2'd0 ? PROG0_BASE : ProgSel == 2'd1 ? PROG1_BASE : PROG2_BASE;
  assign retire = state == RUN && !Stall;
  assign InstValid = state == RUN;
  assign Busy = state == RUN;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      InstAddress <= PROG0_BASE;
      RetireCount <= '0;
      Fault <= 1'b0;
      Done <= 1'b0;
    end else begin
      state <= state_n;
      InstAddress <= pc_n;
      RetireCount <= count_n;
      Fault <= fault_n;
      Done <= done_n;
    end
  // Halt has priority over branch; only sequential fall-through off the last word faults
  always_comb begin
    state_n = state;
    pc_n = InstAddress;
    count_n = RetireCount;
    fault_n = Fault;
    done_n = 1'b0;
    if (state == IDLE && Start) begin
      state_n = RUN;
      pc_n = base;
      count_n = '0;
      fault_n = 1'b0;
    end else if (retire) begin
      count_n = &RetireCount ? RetireCount : RetireCount + 1'b1;
      if (HaltReq) begin
        state_n = IDLE;
        done_n = 1'b1;
      end else if (BranchEn)
        pc_n = BranchAbs ? Target : InstAddress + Target;
      else if (&InstAddress) begin
        state_n = IDLE;
        fault_n = 1'b1;
      end else
        pc_n = InstAddress + 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of launch, stepping, branches, stalls, fault, reset abort and saturation
module tb_fetch_sequencer;
  logic Clk = 1'b0, Reset = 1'b1, Start = 1'b0, Stall = 1'b0, HaltReq = 1'b0;
  logic BranchEn = 1'b0, BranchAbs = 1'b0;
  logic [1:0] ProgSel = 2'd0;
  logic [10:0] Target = '0, InstAddress;
  logic InstValid, Busy, Done, Fault;
  logic [15:0] RetireCount;
  int errors = 0, checks = 0;

  fetch_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .Stall(Stall),
    .HaltReq(HaltReq), .BranchEn(BranchEn), .BranchAbs(BranchAbs), .Target(Target),
    .InstAddress(InstAddress), .InstValid(InstValid), .Busy(Busy), .Done(Done),
    .Fault(Fault), .RetireCount(RetireCount)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [10:0] pc, input logic busy,
                           input logic done, input logic fault, input logic [15:0] cnt);
    chk({tag, ".pc"}, 32'(InstAddress), 32'(pc));
    chk({tag, ".busy"}, 32'(Busy), 32'(busy));
    chk({tag, ".valid"}, 32'(InstValid), 32'(busy));
    chk({tag, ".done"}, 32'(Done), 32'(done));
    chk({tag, ".fault"}, 32'(Fault), 32'(fault));
    chk({tag, ".count"}, 32'(RetireCount), 32'(cnt));
  endtask

  initial begin
    #3;
    chk_state("reset", 11'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    tick();
    Reset = 1'b0;
    tick();
    chk_state("idle_hold", 11'd0, 1'b0, 1'b0, 1'b0, 16'd0);

    Start = 1'b1; ProgSel = 2'd1;
    tick();
    Start = 1'b0;
    chk_state("p1_launch", 11'd256, 1'b1, 1'b0, 1'b0, 16'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("p1_step.pc", 32'(InstAddress), 32'(256 + i));
    end
    HaltReq = 1'b1;
    tick();
    HaltReq = 1'b0;
    chk_state("p1_halt", 11'd260, 1'b0, 1'b1, 1'b0, 16'd5);
    tick();
    chk_state("p1_after", 11'd260, 1'b0, 1'b0, 1'b0, 16'd5);

    Start = 1'b1; ProgSel = 2'd0;
    tick();
    Start = 1'b0;
    chk_state("p0_launch", 11'd0, 1'b1, 1'b0, 1'b0, 16'd0);
    repeat (10) tick();
    chk("p0_at10.pc", 32'(InstAddress), 32'd10);
    BranchEn = 1'b1; BranchAbs = 1'b0; Target = 11'h7FE;
    tick();
    chk_state("br_rel", 11'd8, 1'b1, 1'b0, 1'b0, 16'd11);
    BranchAbs = 1'b1; Target = 11'd40;
    tick();
    chk_state("br_abs", 11'd40, 1'b1, 1'b0, 1'b0, 16'd12);

    Target = 11'd100; Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_state("stall_br", 11'd40, 1'b1, 1'b0, 1'b0, 16'd12);
    end
    Stall = 1'b0;
    tick();
    chk_state("br_after_stall", 11'd100, 1'b1, 1'b0, 1'b0, 16'd13);
    BranchEn = 1'b0; HaltReq = 1'b1; Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_state("stall_halt", 11'd100, 1'b1, 1'b0, 1'b0, 16'd13);
    end
    Stall = 1'b0;
    tick();
    HaltReq = 1'b0;
    chk_state("halt_after_stall", 11'd100, 1'b0, 1'b1, 1'b0, 16'd14);

    Start = 1'b1; ProgSel = 2'd0;
    tick();
    Start = 1'b0;
    BranchEn = 1'b1; BranchAbs = 1'b1; Target = 11'd2045;
    tick();
    BranchEn = 1'b0;
    chk("run_end.pc2045", 32'(InstAddress), 32'd2045);
    tick();
    tick();
    chk("run_end.pc2047", 32'(InstAddress), 32'd2047);
    chk("run_end.busy", 32'(Busy), 32'd1);
    tick();
    chk("fault.flag", 32'(Fault), 32'd1);
    chk("fault.busy", 32'(Busy), 32'd0);
    chk("fault.done", 32'(Done), 32'd0);
    chk("fault.pc", 32'(InstAddress), 32'd2047);
    tick();
    chk("fault_sticky.flag", 32'(Fault), 32'd1);
    chk("fault_sticky.done", 32'(Done), 32'd0);
    Start = 1'b1; ProgSel = 2'd2;
    tick();
    Start = 1'b0;
    chk_state("fault_clear", 11'd512, 1'b1, 1'b0, 1'b0, 16'd0);

    Start = 1'b1; ProgSel = 2'd1;
    tick();
    Start = 1'b0;
    chk_state("start_in_run", 11'd513, 1'b1, 1'b0, 1'b0, 16'd1);
    tick();
    chk("run2.pc", 32'(InstAddress), 32'd514);
    #2;
    Reset = 1'b1;
    #1;
    chk_state("async_reset", 11'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    tick();
    chk_state("reset_held", 11'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    Reset = 1'b0;

    Start = 1'b1; ProgSel = 2'd3;
    tick();
    Start = 1'b0;
    chk_state("p3_launch", 11'd512, 1'b1, 1'b0, 1'b0, 16'd0);
    BranchEn = 1'b1; BranchAbs = 1'b1; Target = 11'd512;
    repeat (65534) tick();
    chk("sat.pre", 32'(RetireCount), 32'd65534);
    tick();
    chk("sat.max", 32'(RetireCount), 32'd65535);
    repeat (4466) tick();
    chk_state("sat.hold", 11'd512, 1'b1, 1'b0, 1'b0, 16'd65535);
    BranchEn = 1'b0; HaltReq = 1'b1;
    tick();
    HaltReq = 1'b0;
    chk_state("sat.halt", 11'd512, 1'b0, 1'b1, 1'b0, 16'd65535);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
